// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite single-port memory slave with configurable data
//               width, depth and wait states, little-endian byte-lane writes
//               and an optional two-cycle ERROR response enabled by the
//               macro AHB_SRAM_ERR_EN (out-of-range, misaligned or oversized
//               transfers). Without the macro, addresses wrap modulo DEPTH,
//               misaligned offsets are masked and HRESP is held at OKAY.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HREADY_Prev,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HBURST,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADY,
    output logic              HRESP
);

    localparam int c_BYTES   = DATA_W / 8;
    localparam int c_OFF_W   = $clog2(c_BYTES);
    localparam int c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_WS_LAST = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [ADDR_W-1:0] c_DEPTH_A = ADDR_W'(DEPTH);

`ifdef AHB_SRAM_ERR_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nx;
    state_t              w_target;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nx;

    // Address-phase fields captured on accept (lane mask stands in for
    // the low address bits and HSIZE).
    logic                r_valid;
    logic                r_write;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_BYTES-1:0]  r_be;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_word_full;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_OFF_W-1:0]  w_off_raw;
    logic [c_OFF_W-1:0]  w_size_mask;
    logic [c_OFF_W-1:0]  w_off;
    logic                w_size_big;
    logic [c_BYTES-1:0]  w_len_mask;
    logic [c_BYTES-1:0]  w_be;
    int                  w_nbytes;
    logic                w_take;
    logic                w_unused;

    // Burst type and the BUSY/SEQ distinction do not affect addressing.
    assign w_unused = ^{HBURST, HTRANS[0]};

    // A new address phase is only taken while this slave shows ready, so an
    // in-flight transfer's captured fields are never overwritten in WAIT/ERR1.
    assign w_take = HSEL & HREADY_Prev & HTRANS[1] & HREADY;

    assign w_word_full = HADDR >> c_OFF_W;
    assign w_idx       = c_IDX_W'(w_word_full % c_DEPTH_A);
    assign w_off_raw   = HADDR[c_OFF_W-1:0];
    assign w_size_big  = (HSIZE > 3'(c_OFF_W));
    // Bits of the lane offset that must be zero for the requested size.
    assign w_size_mask = w_size_big ? '1 : ~({c_OFF_W{1'b1}} << HSIZE);
    assign w_off       = w_off_raw & ~w_size_mask;
    assign w_be        = w_len_mask << w_off;

    // Contiguous lane mask of (1 << HSIZE) bytes, clamped to the bus width.
    always_comb begin
        w_nbytes   = w_size_big ? c_BYTES : (1 << HSIZE);
        w_len_mask = '0;
        for (int b = 0; b < c_BYTES; b++) begin
            w_len_mask[b] = (b < w_nbytes);
        end
    end

    // Destination state for an accepted transfer.
    always_comb begin
        w_target = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
`ifdef AHB_SRAM_ERR_EN
        if ((w_word_full >= c_DEPTH_A) || ((w_off_raw & w_size_mask) != '0) || w_size_big) begin
            w_target = S_ERR1;
        end
`endif
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE, S_DATA: begin
                w_state_nx = w_take ? w_target : S_IDLE;
            end
            S_WAIT: begin
                if (r_cnt == 4'(c_WS_LAST)) begin
                    w_state_nx = S_DATA;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 4'd1;
                end
            end
`ifdef AHB_SRAM_ERR_EN
            S_ERR1: begin
                w_state_nx = S_ERR2;
            end
            S_ERR2: begin
                w_state_nx = w_take ? w_target : S_IDLE;
            end
`endif
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Bus responses decoded from state; read data is the full stored word.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        case (r_state)
            S_WAIT: begin
                HREADY = 1'b0;
            end
            S_DATA: begin
                if (r_valid && !r_write) begin
                    HRDATA = r_mem[r_idx];
                end
            end
`ifdef AHB_SRAM_ERR_EN
            S_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            S_ERR2: begin
                HRESP = 1'b1;
            end
`endif
            default: begin
                HREADY = 1'b1;
            end
        endcase
    end

    // State, counter and address-phase capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (HREADY) begin
                r_valid <= w_take;
                if (w_take) begin
                    r_write <= HWRITE;
                    r_idx   <= w_idx;
                    r_be    <= w_be;
                end
            end
        end
    end

    // Byte-lane write at the edge that ends the write data phase; the state
    // drops to IDLE immediately on reset, so an aborted write never lands.
    always_ff @(posedge HCLK) begin
        if (r_state == S_DATA && r_valid && r_write) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Directed bench for ahb_sram_slave: three instances with
//               WAIT_STATES 0, 2 and 3 share one bus; each slave's HREADY is
//               fed back as its own HREADY_Prev. Expectations follow the
//               AHB_SRAM_ERR_EN build selection.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_NSEQ = 2'b10;
    localparam logic [1:0] c_SEQ  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        rst2_n;
    logic        sel0, sel2, sel3;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] rdata0, rdata2, rdata3;
    logic        hr0, hr2, hr3;
    logic        resp0, resp2, resp3;

    int n_assert;
    int n_fail;
    int lows;

    ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HREADY_Prev(hr0),
        .HTRANS(htrans), .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite),
        .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rdata0), .HREADY(hr0), .HRESP(resp0)
    );

    ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESETn(rst2_n), .HSEL(sel2), .HREADY_Prev(hr2),
        .HTRANS(htrans), .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite),
        .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rdata2), .HREADY(hr2), .HRESP(resp2)
    );

    ahb_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(sel3), .HREADY_Prev(hr3),
        .HTRANS(htrans), .HBURST(hburst), .HSIZE(hsize), .HWRITE(hwrite),
        .HADDR(haddr), .HWDATA(hwdata), .HRDATA(rdata3), .HREADY(hr3), .HRESP(resp3)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ap(input logic [1:0] t, input logic w, input logic [31:0] a, input logic [2:0] s);
        htrans = t;
        hwrite = w;
        haddr  = a;
        hsize  = s;
    endtask

    // Counts low-HREADY cycles of the WS=3 slave, bounded.
    task automatic wait_ready3(output int n);
        n = 0;
        while (hr3 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wr3(input logic [31:0] a, input logic [31:0] d);
        int n;
        ap(c_NSEQ, 1'b1, a, 3'd2);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        hwdata = d;
        wait_ready3(n);
        chk("ws3 write wait cycles", 32'(n), 32'd3);
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rst2_n   = 1'b0;
        sel0     = 1'b0;
        sel2     = 1'b0;
        sel3     = 1'b0;
        hburst   = 3'b000;
        hwdata   = 32'h0;
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        #1;
        chk("reset HREADY", {31'b0, hr0}, 32'd1);
        chk("reset HRESP", {31'b0, resp0}, 32'd0);
        chk("reset HRDATA", rdata0, 32'h0);
        tick();
        tick();
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        tick();

        // Back-to-back write then read, zero wait.
        sel0 = 1'b1;
        ap(c_NSEQ, 1'b1, 32'h10, 3'd2);
        tick();
        hwdata = 32'hDEADBEEF;
        ap(c_NSEQ, 1'b0, 32'h10, 3'd2);
        chk("b2b write data HREADY", {31'b0, hr0}, 32'd1);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        chk("b2b read data HREADY", {31'b0, hr0}, 32'd1);
        chk("b2b read HRDATA", rdata0, 32'hDEADBEEF);
        tick();
        chk("idle HRDATA", rdata0, 32'h0);

        // Byte and halfword lane writes.
        ap(c_NSEQ, 1'b1, 32'h10, 3'd2);
        tick();
        hwdata = 32'h11223344;
        ap(c_NSEQ, 1'b1, 32'h13, 3'd0);
        tick();
        hwdata = 32'hAA000000;
        ap(c_NSEQ, 1'b0, 32'h10, 3'd2);
        tick();
        chk("byte lane 3 write", rdata0, 32'hAA223344);
        ap(c_NSEQ, 1'b1, 32'h12, 3'd1);
        tick();
        hwdata = 32'hBEEF0000;
        ap(c_NSEQ, 1'b0, 32'h10, 3'd2);
        tick();
        chk("half upper write", rdata0, 32'hBEEF3344);
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        tick();

        // Misaligned halfword write to 0x01.
        ap(c_NSEQ, 1'b1, 32'h00, 3'd2);
        tick();
        hwdata = 32'h87654321;
        ap(c_NSEQ, 1'b1, 32'h01, 3'd1);
        tick();
        hwdata = 32'h0000BEEF;
`ifdef AHB_SRAM_ERR_EN
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        chk("misalign ERR1 HREADY", {31'b0, hr0}, 32'd0);
        chk("misalign ERR1 HRESP", {31'b0, resp0}, 32'd1);
        tick();
        chk("misalign ERR2 HREADY", {31'b0, hr0}, 32'd1);
        chk("misalign ERR2 HRESP", {31'b0, resp0}, 32'd1);
        ap(c_NSEQ, 1'b0, 32'h00, 3'd2);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        chk("misalign mem unchanged", rdata0, 32'h87654321);
        chk("read after ERR2 HRESP", {31'b0, resp0}, 32'd0);
`else
        chk("misalign write HRESP", {31'b0, resp0}, 32'd0);
        chk("misalign write HREADY", {31'b0, hr0}, 32'd1);
        ap(c_NSEQ, 1'b0, 32'h00, 3'd2);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        chk("misalign masked to lanes 0-1", rdata0, 32'h8765BEEF);
`endif
        tick();

        // Out-of-range address 0x400 (word 256).
`ifdef AHB_SRAM_ERR_EN
        ap(c_NSEQ, 1'b0, 32'h400, 3'd2);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        chk("range ERR1 HREADY", {31'b0, hr0}, 32'd0);
        chk("range ERR1 HRESP", {31'b0, resp0}, 32'd1);
        chk("range ERR1 HRDATA", rdata0, 32'h0);
        tick();
        chk("range ERR2 HREADY", {31'b0, hr0}, 32'd1);
        chk("range ERR2 HRESP", {31'b0, resp0}, 32'd1);
        chk("range ERR2 HRDATA", rdata0, 32'h0);
        tick();
        chk("range idle HRESP", {31'b0, resp0}, 32'd0);
`else
        ap(c_NSEQ, 1'b1, 32'h400, 3'd2);
        tick();
        hwdata = 32'h00000055;
        ap(c_NSEQ, 1'b0, 32'h000, 3'd2);
        chk("wrap write HRESP", {31'b0, resp0}, 32'd0);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        chk("wrap read HRDATA", rdata0, 32'h00000055);
        chk("wrap read HRESP", {31'b0, resp0}, 32'd0);
        tick();
`endif
        sel0 = 1'b0;

        // Three wait states; a SEQ beat held during the waits waits too.
        sel3 = 1'b1;
        wr3(32'h20, 32'hCAFEF00D);
        wr3(32'h24, 32'h01234567);
        ap(c_NSEQ, 1'b0, 32'h20, 3'd2);
        tick();
        ap(c_SEQ, 1'b0, 32'h24, 3'd2);
        chk("ws3 first wait HREADY", {31'b0, hr3}, 32'd0);
        wait_ready3(lows);
        chk("ws3 read wait cycles", 32'(lows), 32'd3);
        chk("ws3 read HRDATA", rdata3, 32'hCAFEF00D);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        chk("ws3 SEQ accepted at ready", {31'b0, hr3}, 32'd0);
        wait_ready3(lows);
        chk("ws3 SEQ wait cycles", 32'(lows), 32'd3);
        chk("ws3 SEQ HRDATA", rdata3, 32'h01234567);
        tick();
        sel3 = 1'b0;

        // Reset asserted while a write is waiting (WAIT_STATES=2).
        sel2 = 1'b1;
        ap(c_NSEQ, 1'b1, 32'h30, 3'd2);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        hwdata = 32'h00001111;
        tick();
        tick();
        chk("ws2 preload data HREADY", {31'b0, hr2}, 32'd1);
        tick();
        ap(c_NSEQ, 1'b1, 32'h30, 3'd2);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        hwdata = 32'hFFFFFFFF;
        chk("ws2 pending write HREADY", {31'b0, hr2}, 32'd0);
        #2;
        rst2_n = 1'b0;
        #1;
        chk("mid-wait reset HREADY", {31'b0, hr2}, 32'd1);
        chk("mid-wait reset HRESP", {31'b0, resp2}, 32'd0);
        chk("mid-wait reset HRDATA", rdata2, 32'h0);
        tick();
        tick();
        rst2_n = 1'b1;
        ap(c_NSEQ, 1'b0, 32'h30, 3'd2);
        tick();
        ap(c_IDLE, 1'b0, 32'h0, 3'd2);
        tick();
        tick();
        chk("aborted write left old data", rdata2, 32'h00001111);
        tick();
        sel2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
